// File: rtl/seq_shift_add_mult_if.sv
// Operand/result handshake bundle for the sequential shift-add multiplier.
// The master drives operands and ack; the slave (multiplier) returns status and result.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH + 1);

    logic                 valid_data;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 ack;
    logic                 busy;
    logic                 Done_Flag;
    logic [2*WIDTH-1:0]   product;
    logic [CW-1:0]        cycles;

    modport master (
        output valid_data, signed_mode, a_in, b_in, ack,
        input  busy, Done_Flag, product, cycles
    );

    modport slave (
        input  valid_data, signed_mode, a_in, b_in, ack,
        output busy, Done_Flag, product, cycles
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier resolving one multiplier bit per clock.
// Signed operands are handled as magnitudes with the sign reapplied at the end.
module seq_shift_add_mult #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                Clock,
    input  logic                Reset,
    seq_shift_add_mult_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [2*WIDTH-1:0]   a_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     b_shift;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_inc;
    logic [CW-1:0]        cycles_q;
    logic                 neg;
    logic                 last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        acc_next = acc;
        if (b_reg[0]) begin
            acc_next = acc + a_reg;
        end
        b_shift    = b_reg >> 1;
        cnt_inc    = cnt + CW'(1);
        last       = (cnt_inc == CW'(WIDTH)) || (EARLY_EXIT && (b_shift == '0));
        next_state = state;
        case (state)
            IDLE:    if (bus.valid_data) next_state = CALC;
            CALC:    if (last)           next_state = DONE;
            DONE:    if (bus.ack)        next_state = IDLE;
            default:                     next_state = IDLE;
        endcase
    end

    // Two's complement magnitude; the most negative value maps onto itself,
    // which is exactly its unsigned magnitude.
    always_comb begin
        a_mag = bus.a_in;
        b_mag = bus.b_in;
        if (bus.signed_mode && bus.a_in[WIDTH-1]) begin
            a_mag = ~bus.a_in + WIDTH'(1);
        end
        if (bus.signed_mode && bus.b_in[WIDTH-1]) begin
            b_mag = ~bus.b_in + WIDTH'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            product_q <= '0;
            cycles_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_data) begin
                        a_reg <= {{WIDTH{1'b0}}, a_mag};
                        b_reg <= b_mag;
                        neg   <= bus.signed_mode & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    a_reg <= a_reg << 1;
                    b_reg <= b_shift;
                    cnt   <= cnt_inc;
                    if (last) begin
                        product_q <= neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
                        cycles_q  <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == CALC) || (state == DONE);
    assign bus.Done_Flag = (state == DONE);
    assign bus.product   = product_q;
    assign bus.cycles    = cycles_q;
endmodule
